adventure_game_v2: RTL and testbench



---
 rtl/adv_game_pkg.sv | 24 ++
 rtl/adv_sword_tracker.sv | 11 +
 rtl/adventure_game_v2.sv | 81 ++++++++
 tb/tb_adventure_game_v2.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/adv_game_pkg.sv
// adv_game_pkg: room encodings, one-hot bit indices and direction codes for adventure_game_v2
package adv_game_pkg;
   typedef enum logic [2:0] {
      VAULT  = 3'd0,
      GRAVE  = 3'd1,
      DEN    = 3'd2,
      STASH  = 3'd3,
      RIVER  = 3'd4,
      TUNNEL = 3'd5,
      CAVE   = 3'd6
   } room_t;
   localparam int ROOM_N   = 7;
   localparam int B_VAULT  = 0;
   localparam int B_GRAVE  = 1;
   localparam int B_DEN    = 2;
   localparam int B_STASH  = 3;
   localparam int B_RIVER  = 4;
   localparam int B_TUNNEL = 5;
   localparam int B_CAVE   = 6;
   localparam logic [3:0] DIR_N = 4'b1000;
   localparam logic [3:0] DIR_S = 4'b0100;
   localparam logic [3:0] DIR_E = 4'b0010;
   localparam logic [3:0] DIR_W = 4'b0001;
endpackage

// File: rtl/adv_sword_tracker.sv
// adv_sword_tracker: sword flag, set on entry to the Secret Sword Stash, cleared by reset
module adv_sword_tracker (
   input  logic clk,
   input  logic reset,
   input  logic set,
   output logic sword
);
   always_ff @(posedge clk)
      if (reset) sword <= 1'b0;
      else if (set) sword <= 1'b1;
endmodule

// File: rtl/adventure_game_v2.sv
// adventure_game_v2: seven-room adventure FSM with lives, saturating move counter and room code
// Optional: ADV_MOVE_LIMIT_EN forces the Graveyard once moves reaches MAX_MOVES.
module adventure_game_v2
   import adv_game_pkg::*;
#(
   parameter int LIVES     = 1,
   parameter int MOVE_W    = 8,
   parameter int MAX_MOVES = 200
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              n,
   input  logic              s,
   input  logic              e,
   input  logic              w,
   output logic [6:0]        room,
   output logic [2:0]        room_code,
   output logic              win,
   output logic              die,
   output logic              sword,
   output logic [3:0]        lives,
   output logic [MOVE_W-1:0] moves
);
   if (MAX_MOVES >= 2 ** MOVE_W) begin : g_bad_cfg
      $error("MAX_MOVES must be < 2**MOVE_W");
   end
   room_t st, st_n;
   logic [3:0] lives_n;
   logic [3:0] dir;
   logic step;
   logic at_limit;
   assign dir = {n, s, e, w};
`ifdef ADV_MOVE_LIMIT_EN
   assign at_limit = moves == MOVE_W'(MAX_MOVES);
`else
   assign at_limit = 1'b0;
`endif
   always_ff @(posedge clk)
      if (reset) begin
         st    <= CAVE;
         lives <= 4'(LIVES);
         moves <= '0;
      end else begin
         st    <= st_n;
         lives <= lives_n;
         if (step && moves != '1) moves <= moves + MOVE_W'(1);
      end
   always_comb begin
      st_n    = st;
      lives_n = lives;
      case (st)
         CAVE:   st_n = dir == DIR_E ? TUNNEL : CAVE;
         TUNNEL: st_n = dir == DIR_W ? CAVE : dir == DIR_S ? RIVER : TUNNEL;
         RIVER:  st_n = dir == DIR_N ? TUNNEL : dir == DIR_W ? STASH : dir == DIR_E ? DEN : RIVER;
         STASH:  st_n = dir == DIR_E ? RIVER : STASH;
         DEN: begin
            st_n    = sword ? VAULT : lives > 4'd1 ? CAVE : GRAVE;
            lives_n = sword ? lives : lives > 4'd1 ? lives - 4'd1 : 4'd0;
         end
         VAULT, GRAVE: st_n = st;
         default: st_n = CAVE;
      endcase
      // only command-driven changes between walkable rooms count as moves
      step = st_n != st && st inside {CAVE, TUNNEL, RIVER, STASH};
      if (at_limit && st inside {CAVE, TUNNEL, RIVER, STASH}) begin
         st_n    = GRAVE;
         lives_n = 4'd0;
         step    = 1'b0;
      end
   end
   adv_sword_tracker u_sword (
      .clk   (clk),
      .reset (reset),
      .set   (st_n == STASH && st != STASH),
      .sword (sword)
   );
   assign room      = 7'b1 << st;
   assign room_code = st;
   assign win       = room[B_VAULT];
   assign die       = room[B_GRAVE];
endmodule

// File: tb/tb_adventure_game_v2.sv
// tb_adventure_game_v2: scoreboard bench driving a classic (LIVES=1) and a multi-life (LIVES=3, MOVE_W=2) instance
module tb_adventure_game_v2;
   logic clk = 1'b0;
   logic reset, n, s, e, w;
   logic [6:0] room1, room3;
   logic [2:0] code1, code3;
   logic win1, win3, die1, die3, sword1, sword3;
   logic [3:0] lives1, lives3;
   logic [7:0] moves1;
   logic [1:0] moves3;
   typedef struct {int code; int sword; int lives; int moves;} mst_t;
   mst_t m1, m3, x;
   mst_t q1[$], q3[$];
   int errors = 0, checks = 0;
   localparam logic [3:0] N = 4'b1000, S = 4'b0100, E = 4'b0010, W = 4'b0001, I = 4'b0000;
`ifdef ADV_MOVE_LIMIT_EN
   localparam int LIM1 = 200, LIM3 = 3;
`else
   localparam int LIM1 = -1, LIM3 = -1;
`endif
   always #5 clk = ~clk;
   adventure_game_v2 #(.LIVES(1), .MOVE_W(8), .MAX_MOVES(200)) d1 (
      .clk(clk), .reset(reset), .n(n), .s(s), .e(e), .w(w),
      .room(room1), .room_code(code1), .win(win1), .die(die1),
      .sword(sword1), .lives(lives1), .moves(moves1)
   );
   adventure_game_v2 #(.LIVES(3), .MOVE_W(2), .MAX_MOVES(3)) d3 (
      .clk(clk), .reset(reset), .n(n), .s(s), .e(e), .w(w),
      .room(room3), .room_code(code3), .win(win3), .die(die3),
      .sword(sword3), .lives(lives3), .moves(moves3)
   );
   // map walk written as a destination table, independent of the RTL structure
   function automatic mst_t mnext(mst_t c, logic [3:0] d, logic r, int lv, int mx, int lim);
      mst_t t = c;
      int tgt = -1;
      if (r) begin
         t.code = 6; t.sword = 0; t.lives = lv; t.moves = 0;
         return t;
      end
      if (c.code == 2) begin
         if (c.sword != 0) t.code = 0;
         else if (c.lives > 1) begin t.code = 6; t.lives = c.lives - 1; end
         else begin t.code = 1; t.lives = 0; end
         return t;
      end
      if (c.code < 2) return t;
      if (c.moves == lim) begin
         t.code = 1; t.lives = 0;
         return t;
      end
      if (c.code == 6 && d == E) tgt = 5;
      if (c.code == 5 && d == W) tgt = 6;
      if (c.code == 5 && d == S) tgt = 4;
      if (c.code == 4 && d == N) tgt = 5;
      if (c.code == 4 && d == W) tgt = 3;
      if (c.code == 4 && d == E) tgt = 2;
      if (c.code == 3 && d == E) tgt = 4;
      if (tgt >= 0) begin
         t.code  = tgt;
         t.moves = c.moves < mx ? c.moves + 1 : mx;
         if (tgt == 3) t.sword = 1;
      end
      return t;
   endfunction
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask
   task automatic check_dut(input string tag, input mst_t c, input logic [6:0] room,
                            input logic [2:0] code, input logic win, input logic die,
                            input logic sword, input logic [3:0] lives, input logic [31:0] moves);
      chk({tag, ".room"}, 32'(room), (1 << c.code) & 127);
      chk({tag, ".code"}, 32'(code), c.code);
      chk({tag, ".win"}, 32'(win), 32'(c.code == 0));
      chk({tag, ".die"}, 32'(die), 32'(c.code == 1));
      chk({tag, ".sword"}, 32'(sword), c.sword);
      chk({tag, ".lives"}, 32'(lives), c.lives);
      chk({tag, ".moves"}, moves, c.moves);
   endtask
   task automatic step(input logic [3:0] d, input logic r, input string tag);
      {n, s, e, w} = d;
      reset = r;
      m1 = mnext(m1, d, r, 1, 255, LIM1);
      m3 = mnext(m3, d, r, 3, 3, LIM3);
      q1.push_back(m1);
      q3.push_back(m3);
      @(posedge clk);
      #1;
      x = q1.pop_front();
      check_dut({tag, "/d1"}, x, room1, code1, win1, die1, sword1, lives1, 32'(moves1));
      x = q3.pop_front();
      check_dut({tag, "/d3"}, x, room3, code3, win3, die3, sword3, lives3, 32'(moves3));
   endtask
   initial begin
      m1 = '{0, 0, 0, 0};
      m3 = '{0, 0, 0, 0};
      {n, s, e, w} = 4'b0;
      reset = 1'b0;
      @(negedge clk);
      step(I, 1, "reset");
      step(E, 0, "die_e1"); step(S, 0, "die_s"); step(E, 0, "die_e2"); step(I, 0, "die_den");
      chk("die.d1.die", 32'(die1), 1);
      chk("die.d1.lives", 32'(lives1), 0);
      chk("die.d1.moves", 32'(moves1), 3);
      chk("die.d1.sword", 32'(sword1), 0);
`ifndef ADV_MOVE_LIMIT_EN
      chk("respawn.d3.code", 32'(code3), 6);
      chk("respawn.d3.lives", 32'(lives3), 2);
`endif
      step(I, 1, "reset2");
      step(E, 0, "win_e"); step(S, 0, "win_s"); step(W, 0, "win_w");
      chk("stash.d1.sword", 32'(sword1), 1);
      step(E, 0, "win_e2"); step(E, 0, "win_e3"); step(I, 0, "win_den");
      chk("win.d1.win", 32'(win1), 1);
      chk("win.d1.moves", 32'(moves1), 5);
      step(N, 0, "vault_n"); step(E, 0, "vault_e"); step(W, 0, "vault_w"); step(S, 0, "vault_s");
      chk("vault_hold.d1.code", 32'(code1), 0);
      step(I, 1, "reset3");
      for (int i = 0; i < 3; i++) begin
         step(E, 0, "lives_e1"); step(S, 0, "lives_s"); step(E, 0, "lives_e2"); step(I, 0, "lives_den");
      end
      chk("lives.d3.die", 32'(die3), 1);
      chk("lives.d3.lives", 32'(lives3), 0);
      step(I, 1, "reset4");
      step(N | E, 0, "multi"); step(I, 0, "idle"); step(W, 0, "cave_w");
      step(S | W, 0, "multi2"); step(N | S | E | W, 0, "multi4");
      chk("hold.d1.code", 32'(code1), 6);
      chk("hold.d1.moves", 32'(moves1), 0);
      step(E, 0, "mid_e1"); step(S, 0, "mid_s"); step(W, 0, "mid_w"); step(E, 0, "mid_e2");
      chk("mid.d1.code", 32'(code1), 4);
      step(E | W, 1, "midreset");
      chk("midreset.d1.sword", 32'(sword1), 0);
      chk("midreset.d3.lives", 32'(lives3), 3);
      step(E, 0, "sat_e1"); step(W, 0, "sat_w1"); step(E, 0, "sat_e2");
      step(W, 0, "sat_w2"); step(E, 0, "sat_e3"); step(W, 0, "sat_w3");
`ifndef ADV_MOVE_LIMIT_EN
      chk("sat.d3.moves", 32'(moves3), 3);
`else
      chk("limit.d3.die", 32'(die3), 1);
`endif
      chk("sat.d1.moves", 32'(moves1), 6);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
